fd_queue: RTL and testbench
===========================

// Module: fd_queue
// PURPOSE
// - Parametrised fetch->decode buffer. Replaces the single FD register with a DEPTH-entry FIFO.
// - Each entry holds an instruction word, its PC, PC+4 and the ISA mode (arm) that was active when it was fetched.
// - Sits between stage_f and the decoder/regfile of the combined ARM/RISC-V pipeline.
// - Lets fetch keep running while decode stalls. Flushes atomically on FlushD.
// PARAMETERS
// - XLEN   32  data/address width of instr, PC and PC+4 fields
// - DEPTH  2   number of entries; power of two, >=2
// PORTS
// - clk        in   1                rising-edge clock
// - rst        in   1                synchronous, active-high reset
// - arm        in   1                current ISA mode; captured per entry on push
// - ValidF     in   1                fetch presents a valid instruction this cycle
// - RDF        in   XLEN             fetched instruction word
// - PCF        in   XLEN             PC of RDF
// - PCPlus4F   in   XLEN             PCF+4
// - ReadyF     out  1                queue can accept a push (not full)
// - StallD     in   1                decode holds its current instruction
// - FlushD     in   1                discard all queued entries
// - ValidD     out  1                head entry valid
// - InstrD     out  XLEN             head instruction
// - PCD        out  XLEN             head PC
// - PCPlus4D   out  XLEN             head PC+4
// - PCPlus8D   out  XLEN             head PC+8; ARM r15 read value
// - ArmD       out  1                head entry ISA mode
// - CountD     out  $clog2(DEPTH+1)  occupancy
// BEHAVIOUR
// - Reset and flush
//   - rst=1 at a posedge: wptr=rptr=count=0. Storage contents are don't-care.
//   - FlushD=1 at a posedge: same result as rst. Flush beats push and pop in that cycle.
// - Handshake
//   - push = ValidF & ReadyF & ~FlushD & ~rst.
//   - pop  = ValidD & ~StallD & ~FlushD & ~rst.
// - ReadyF = (count != DEPTH). It is a function of registered state only, with no combinational path from StallD.
//   - When full, a push is refused even if a pop happens in the same cycle.
// - ValidD = (count != 0).
// - Head outputs are combinational reads of entry[rptr].
//   - When ValidD=0: InstrD, PCD, PCPlus4D, PCPlus8D, ArmD and CountD are all 0, i.e. a bubble with an all-zero instruction word.
// - Latency: an entry pushed at posedge N is visible on the head outputs after posedge N (one cycle), even when the queue was empty.
//   - There is no fall-through bypass.
// - Pointers
//   - Each pointer is $clog2(DEPTH) bits and wraps modulo DEPTH.
//   - push: write entry[wptr] = {RDF, PCF, PCPlus4F, arm}, then wptr++.
//   - pop: rptr++.
// - Count update
//   - push & ~pop: count+1.
//   - pop & ~push: count-1.
//   - push & pop: count unchanged. This is legal when 0 < count < DEPTH.
//   - Push with pop at count==0 cannot occur, because pop needs ValidD.
// - PCPlus8D = PCPlus4D + 4, modulo 2^XLEN. Wraps 0xFFFFFFFC -> 0x00000000 with no carry out.
// - arm is sampled per entry, so a mode change never retags instructions already queued.
// - StallD with the queue full and ValidF=1: state holds, ReadyF=0, and fetch must hold RDF/PCF.
// - ValidF=0: no push, regardless of RDF contents.
// STRUCTURE
// - Package fd_pkg holds:
//   - typedef struct packed {logic [XLEN-1:0] instr, pc, pcplus4; logic arm;} fd_entry_t;
//   - localparam XLEN_DEF=32 and FD_DEPTH_DEF=2.
// - No sub-module. Storage is an unpacked array of fd_entry_t in this file; pointer/count logic is in one always_ff.
// TESTING
// - Reset: hold rst=1 for 2 cycles with ValidF=1 -> ValidD=0, CountD=0, ReadyF=1, all head fields 0.
// - Fill with StallD=1 (DEPTH=2): push PC 0x100 then 0x104 -> CountD=2, ReadyF=0; a third push of 0x108 is refused; head PCD=0x100.
// - Drain: release StallD, ValidF=0 -> PCD=0x100, then 0x104 (PCPlus8D=0x108, then 0x10C), then ValidD=0.
// - Streaming: continuous ValidF, StallD=0 -> one instruction per cycle, CountD steady at 1, PC order preserved, no entry dropped.
// - Flush priority: CountD=1, assert FlushD together with ValidF=1 -> next cycle CountD=0, ValidD=0, pushed entry discarded.
// - Mode tag and wrap: push with arm=1 (PCF=0xFFFFFFF8), then arm=0 -> ArmD=1 with PCPlus8D=0x00000000 for the first entry, ArmD=0 for the second.

Source files
------------

// File: rtl/fd_pkg.sv
// Shared types and defaults for the fetch->decode queue.
package fd_pkg;

   localparam int XLEN_DEF     = 32;
   localparam int FD_DEPTH_DEF = 2;

   typedef struct packed {
      logic [XLEN_DEF-1:0] instr;
      logic [XLEN_DEF-1:0] pc;
      logic [XLEN_DEF-1:0] pcplus4;
      logic                arm;
   } fd_entry_t;

endpackage

// File: rtl/fd_queue.sv
// Fetch->decode FIFO. Fetch keeps running while decode stalls; a flush empties it atomically.
// Head outputs read the stored entry combinationally and are forced to zero when the queue is empty.
module fd_queue
   import fd_pkg::*;
#(
   parameter int XLEN  = XLEN_DEF,
   parameter int DEPTH = FD_DEPTH_DEF
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       arm,
   input  logic                       ValidF,
   input  logic [XLEN-1:0]            RDF,
   input  logic [XLEN-1:0]            PCF,
   input  logic [XLEN-1:0]            PCPlus4F,
   output logic                       ReadyF,
   input  logic                       StallD,
   input  logic                       FlushD,
   output logic                       ValidD,
   output logic [XLEN-1:0]            InstrD,
   output logic [XLEN-1:0]            PCD,
   output logic [XLEN-1:0]            PCPlus4D,
   output logic [XLEN-1:0]            PCPlus8D,
   output logic                       ArmD,
   output logic [$clog2(DEPTH+1)-1:0] CountD
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH+1);
   localparam logic [AW-1:0]   PTR_ONE  = AW'(1);
   localparam logic [CW-1:0]   CNT_ONE  = CW'(1);
   localparam logic [CW-1:0]   CNT_FULL = CW'(DEPTH);
   localparam logic [XLEN-1:0] FOUR     = XLEN'(4);

   fd_entry_t       r_mem [DEPTH];
   logic [AW-1:0]   r_wptr;
   logic [AW-1:0]   r_rptr;
   logic [CW-1:0]   r_count;

   logic            w_push;
   logic            w_pop;
   fd_entry_t       w_head;

   // ReadyF depends only on registered count, so a full queue refuses a push
   // even when decode pops in the same cycle.
   assign ReadyF = (r_count != CNT_FULL);
   assign ValidD = (r_count != '0);

   assign w_push = ValidF & ReadyF & ~FlushD & ~rst;
   assign w_pop  = ValidD & ~StallD & ~FlushD & ~rst;

   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem[r_wptr] <= '{instr: RDF, pc: PCF, pcplus4: PCPlus4F, arm: arm};
      end
   end

   always_ff @(posedge clk) begin
      if (rst || FlushD) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
      end else begin
         if (w_push) begin
            r_wptr <= r_wptr + PTR_ONE;
         end
         if (w_pop) begin
            r_rptr <= r_rptr + PTR_ONE;
         end
         if (w_push && !w_pop) begin
            r_count <= r_count + CNT_ONE;
         end else if (w_pop && !w_push) begin
            r_count <= r_count - CNT_ONE;
         end
      end
   end

   always_comb begin
      w_head   = r_mem[r_rptr];
      InstrD   = '0;
      PCD      = '0;
      PCPlus4D = '0;
      PCPlus8D = '0;
      ArmD     = 1'b0;
      CountD   = r_count;
      if (ValidD) begin
         InstrD   = w_head.instr;
         PCD      = w_head.pc;
         PCPlus4D = w_head.pcplus4;
         PCPlus8D = w_head.pcplus4 + FOUR;
         ArmD     = w_head.arm;
      end
   end

endmodule

// File: tb/tb_fd_queue.sv
// Directed vector bench for fd_queue (DEPTH=2, XLEN=32).
module tb_fd_queue;

   logic        clk;
   logic        rst;
   logic        arm;
   logic        ValidF;
   logic [31:0] RDF;
   logic [31:0] PCF;
   logic [31:0] PCPlus4F;
   logic        ReadyF;
   logic        StallD;
   logic        FlushD;
   logic        ValidD;
   logic [31:0] InstrD;
   logic [31:0] PCD;
   logic [31:0] PCPlus4D;
   logic [31:0] PCPlus8D;
   logic        ArmD;
   logic [1:0]  CountD;

   fd_queue #(.XLEN(32), .DEPTH(2)) dut (
      .clk      (clk),
      .rst      (rst),
      .arm      (arm),
      .ValidF   (ValidF),
      .RDF      (RDF),
      .PCF      (PCF),
      .PCPlus4F (PCPlus4F),
      .ReadyF   (ReadyF),
      .StallD   (StallD),
      .FlushD   (FlushD),
      .ValidD   (ValidD),
      .InstrD   (InstrD),
      .PCD      (PCD),
      .PCPlus4D (PCPlus4D),
      .PCPlus8D (PCPlus8D),
      .ArmD     (ArmD),
      .CountD   (CountD)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        rst;
      logic        vf;
      logic        st;
      logic        fl;
      logic        arm;
      logic [31:0] pc;
      logic        e_vd;
      logic        e_rdy;
      logic [1:0]  e_cnt;
      logic [31:0] e_pcd;
      logic [31:0] e_p8;
      logic        e_arm;
   } vec_t;

   vec_t vecs[$];
   int   n_vec;
   int   n_bad;

   function automatic logic [31:0] instr_of(input logic [31:0] pc);
      return pc ^ 32'hE5A0_1234;
   endfunction

   task automatic add(input logic r, input logic vf, input logic st, input logic fl,
                      input logic a, input logic [31:0] pc,
                      input logic vd, input logic rdy, input logic [1:0] cnt,
                      input logic [31:0] pcd, input logic [31:0] p8, input logic ad);
      vec_t v;
      v.rst = r; v.vf = vf; v.st = st; v.fl = fl; v.arm = a; v.pc = pc;
      v.e_vd = vd; v.e_rdy = rdy; v.e_cnt = cnt; v.e_pcd = pcd; v.e_p8 = p8; v.e_arm = ad;
      vecs.push_back(v);
   endtask

   task automatic drive(input vec_t v);
      rst    = v.rst;
      ValidF = v.vf;
      StallD = v.st;
      FlushD = v.fl;
      arm    = v.arm;
      PCF    = v.pc;
      if (v.vf) begin
         RDF      = instr_of(v.pc);
         PCPlus4F = v.pc + 32'd4;
      end else begin
         RDF      = $urandom;
         PCPlus4F = $urandom;
      end
   endtask

   task automatic check(input int idx, input vec_t v);
      logic [31:0] e_ins;
      logic [31:0] e_p4;
      e_ins = v.e_vd ? instr_of(v.e_pcd) : 32'd0;
      e_p4  = v.e_vd ? v.e_pcd + 32'd4 : 32'd0;
      n_vec++;
      if (ValidD !== v.e_vd || ReadyF !== v.e_rdy || CountD !== v.e_cnt ||
          PCD !== v.e_pcd || PCPlus4D !== e_p4 || PCPlus8D !== v.e_p8 ||
          InstrD !== e_ins || ArmD !== v.e_arm) begin
         n_bad++;
         $display("FAIL vec%0d: got vd=%b rdy=%b cnt=%0d pc=%h p4=%h p8=%h ins=%h arm=%b, want vd=%b rdy=%b cnt=%0d pc=%h p4=%h p8=%h ins=%h arm=%b",
                  idx, ValidD, ReadyF, CountD, PCD, PCPlus4D, PCPlus8D, InstrD, ArmD,
                  v.e_vd, v.e_rdy, v.e_cnt, v.e_pcd, e_p4, v.e_p8, e_ins, v.e_arm);
      end
   endtask

   task automatic expect_bit(input string name, input logic got, input logic want);
      n_vec++;
      if (got !== want) begin
         n_bad++;
         $display("FAIL %s: got %b want %b", name, got, want);
      end
   endtask

   initial begin
      n_vec = 0;
      n_bad = 0;
      rst = 1'b1; ValidF = 1'b0; StallD = 1'b0; FlushD = 1'b0; arm = 1'b0;
      RDF = '0; PCF = '0; PCPlus4F = '0;

      //   rst vf st fl arm pc            | vd rdy cnt pcd          p8           arm
      add(1, 1, 0, 0, 0, 32'h100,          0, 1, 0, 32'h0,        32'h0,        0);
      add(1, 1, 0, 0, 0, 32'h100,          0, 1, 0, 32'h0,        32'h0,        0);
      add(0, 1, 1, 0, 0, 32'h100,          1, 1, 1, 32'h100,      32'h108,      0);
      add(0, 1, 1, 0, 0, 32'h104,          1, 0, 2, 32'h100,      32'h108,      0);
      add(0, 1, 1, 0, 0, 32'h108,          1, 0, 2, 32'h100,      32'h108,      0);
      add(0, 0, 0, 0, 0, 32'h0,            1, 1, 1, 32'h104,      32'h10C,      0);
      add(0, 0, 0, 0, 0, 32'h0,            0, 1, 0, 32'h0,        32'h0,        0);
      add(0, 1, 0, 0, 0, 32'h200,          1, 1, 1, 32'h200,      32'h208,      0);
      add(0, 1, 0, 0, 0, 32'h204,          1, 1, 1, 32'h204,      32'h20C,      0);
      add(0, 1, 0, 0, 0, 32'h208,          1, 1, 1, 32'h208,      32'h210,      0);
      add(0, 1, 0, 0, 0, 32'h20C,          1, 1, 1, 32'h20C,      32'h214,      0);
      add(0, 1, 0, 1, 0, 32'h210,          0, 1, 0, 32'h0,        32'h0,        0);
      add(0, 0, 0, 0, 0, 32'h0,            0, 1, 0, 32'h0,        32'h0,        0);
      add(0, 1, 1, 0, 0, 32'h300,          1, 1, 1, 32'h300,      32'h308,      0);
      add(0, 1, 1, 0, 0, 32'h304,          1, 0, 2, 32'h300,      32'h308,      0);
      add(0, 1, 0, 0, 0, 32'h308,          1, 1, 1, 32'h304,      32'h30C,      0);
      add(0, 0, 0, 0, 0, 32'h0,            0, 1, 0, 32'h0,        32'h0,        0);
      add(0, 1, 1, 0, 1, 32'hFFFFFFF8,     1, 1, 1, 32'hFFFFFFF8, 32'h0,        1);
      add(0, 1, 1, 0, 0, 32'hFFFFFFFC,     1, 0, 2, 32'hFFFFFFF8, 32'h0,        1);
      add(0, 0, 0, 0, 1, 32'h0,            1, 1, 1, 32'hFFFFFFFC, 32'h4,        0);
      add(0, 0, 0, 0, 1, 32'h0,            0, 1, 0, 32'h0,        32'h0,        0);
      add(0, 0, 0, 0, 0, 32'h0,            0, 1, 0, 32'h0,        32'h0,        0);
      add(0, 1, 1, 0, 0, 32'h400,          1, 1, 1, 32'h400,      32'h408,      0);
      add(1, 1, 1, 0, 0, 32'h404,          0, 1, 0, 32'h0,        32'h0,        0);

      foreach (vecs[i]) begin
         @(negedge clk);
         drive(vecs[i]);
         @(posedge clk);
         #1;
         check(i, vecs[i]);
      end

      // No fall-through: a push presented to an empty queue is invisible before the edge.
      @(negedge clk);
      rst = 1'b0; FlushD = 1'b0; StallD = 1'b1; ValidF = 1'b1; arm = 1'b0;
      PCF = 32'h500; RDF = instr_of(32'h500); PCPlus4F = 32'h504;
      #1;
      expect_bit("no_bypass_validd", ValidD, 1'b0);
      @(posedge clk); #1;
      expect_bit("push_visible", ValidD, 1'b1);
      @(negedge clk);
      PCF = 32'h504; RDF = instr_of(32'h504); PCPlus4F = 32'h508;
      @(posedge clk); #1;
      expect_bit("full_ready", ReadyF, 1'b0);
      // ReadyF must not react combinationally to StallD.
      StallD = 1'b0;
      #1;
      expect_bit("ready_no_stall_path", ReadyF, 1'b0);
      StallD = 1'b1;
      @(negedge clk);
      rst = 1'b1; ValidF = 1'b0;
      @(posedge clk); #1;
      expect_bit("final_reset_empty", ValidD, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
